// File: rtl/sniffer_pkg.sv
// Shared types and helpers for the Ethernet sniffer datapath.
package sniffer_pkg;

   localparam int BYTE_W = 8;
   localparam int WORD_W = 32;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HDR     = 3'd1,
      PAYLOAD = 3'd2,
      TAIL    = 3'd3,
      FLUSH   = 3'd4,
      CLEAR   = 3'd5
   } pe_state_t;

   // Expands per-lane byte enables into a 32-bit data mask.
   function automatic logic [WORD_W-1:0] be_mask(input logic [3:0] rx_be);
      logic [WORD_W-1:0] mask;
      mask = {WORD_W{1'b0}};
      for (int i = 0; i < 4; i++) begin
         mask[i*BYTE_W +: BYTE_W] = {BYTE_W{rx_be[i]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/byte_realigner.sv
// Hold register and lane mux that shift the payload so its first byte lands in lane 3.
module byte_realigner
   import sniffer_pkg::*;
#(
   parameter int ALIGN = 2
)(
   input  logic              clk,
   input  logic              n_rst,
   input  logic              load,
   input  logic              shift,
   input  logic              drain,
   input  logic [WORD_W-1:0] in_data,
   output logic [WORD_W-1:0] out_word
);

   localparam int KEEP = 4 - ALIGN;

   logic [BYTE_W*KEEP-1:0] hold_r;
   logic [WORD_W-1:0]      shift_word_s;
   logic [WORD_W-1:0]      drain_word_s;

   // Hold register keeps the low bytes that spill into the next output word.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         hold_r <= {(BYTE_W*KEEP){1'b0}};
      end else if (load || shift) begin
         hold_r <= in_data[BYTE_W*KEEP-1:0];
      end else begin
         hold_r <= hold_r;
      end
   end

   generate
      if (ALIGN == 0) begin : g_pass
         assign shift_word_s = in_data;
         assign drain_word_s = {WORD_W{1'b0}};
      end else begin : g_shift
         assign shift_word_s = {hold_r, in_data[WORD_W-1:BYTE_W*KEEP]};
         assign drain_word_s = {hold_r, {(BYTE_W*ALIGN){1'b0}}};
      end
   endgenerate

   // Select the realigned word for the current control.
   always_comb begin
      out_word = {WORD_W{1'b0}};
      if (shift) begin
         out_word = shift_word_s;
      end else if (drain) begin
         out_word = drain_word_s;
      end else begin
         out_word = {WORD_W{1'b0}};
      end
   end

endmodule

// File: rtl/payload_extractor.sv
// Strips frame headers, realigns the payload for the string comparator,
// flushes the compare window and clears it between frames.
module payload_extractor
   import sniffer_pkg::*;
#(
   parameter int HDR_BYTES   = 14,
   parameter int FLUSH_WORDS = 5
)(
   input  logic              clk,
   input  logic              n_rst,
   input  logic              rx_valid,
   input  logic              rx_sof,
   input  logic              rx_eof,
   input  logic [3:0]        rx_be,
   input  logic [WORD_W-1:0] rx_data,
   output logic              rx_ready,
   output logic              cmp_valid,
   output logic [WORD_W-1:0] cmp_data,
   output logic              cmp_clear,
   output logic              frame_done,
   output logic              frame_abort
);

   localparam int ALIGN    = HDR_BYTES % 4;
   localparam int HCW      = $clog2(HDR_BYTES + 4);
   localparam int FCW      = $clog2(FLUSH_WORDS + 1);
   localparam int RES_LANE = (ALIGN == 0) ? 3 : 3 - ALIGN;
   localparam logic [HCW-1:0] HDR_N    = HCW'(HDR_BYTES);
   localparam logic [HCW-1:0] HDR_STEP = HCW'(4);
   localparam logic [FCW-1:0] FLUSH_N  = FCW'(FLUSH_WORDS);
   localparam logic [FCW-1:0] FLUSH_1  = FCW'(1);

   pe_state_t         state_r, state_s;
   logic [HCW-1:0]    hdr_cnt_r, hdr_cnt_s;
   logic [FCW-1:0]    flush_cnt_r, flush_cnt_s;
   logic              accept_s, hdr_end_s, residual_s;
   logic              load_s, shift_s, drain_s;
   logic              cmp_valid_s, cmp_clear_s, frame_abort_s;
   logic [WORD_W-1:0] in_masked_s, realign_word_s;

   assign accept_s    = rx_valid && rx_ready;
   assign hdr_end_s   = (hdr_cnt_r + HDR_STEP) >= HDR_N;
   // Residual bytes exist when the eof word carries more than ALIGN valid lanes.
   assign residual_s  = (ALIGN != 0) && rx_be[RES_LANE];
   assign in_masked_s = rx_eof ? (rx_data & be_mask(rx_be)) : rx_data;

   byte_realigner #(.ALIGN(ALIGN)) u_realigner (
      .clk      (clk),
      .n_rst    (n_rst),
      .load     (load_s),
      .shift    (shift_s),
      .drain    (drain_s),
      .in_data  (in_masked_s),
      .out_word (realign_word_s)
   );

   // Next-state, counter and output-request decode.
   always_comb begin
      state_s       = state_r;
      hdr_cnt_s     = hdr_cnt_r;
      flush_cnt_s   = flush_cnt_r;
      load_s        = 1'b0;
      shift_s       = 1'b0;
      drain_s       = 1'b0;
      cmp_valid_s   = 1'b0;
      cmp_clear_s   = 1'b0;
      frame_abort_s = 1'b0;
      case (state_r)
         IDLE, HDR: begin
            if (!accept_s) begin
               state_s = state_r;
            end else if (state_r == IDLE && !rx_sof) begin
               state_s = IDLE;
            end else if (state_r == HDR && rx_sof) begin
               frame_abort_s = 1'b1;
               flush_cnt_s   = FLUSH_N;
               state_s       = FLUSH;
            end else begin
               hdr_cnt_s = hdr_end_s ? HDR_N : hdr_cnt_r + HDR_STEP;
               if (rx_eof) begin
                  state_s = CLEAR;
               end else if (hdr_end_s) begin
                  load_s  = 1'b1;
                  state_s = PAYLOAD;
               end else begin
                  state_s = HDR;
               end
            end
         end
         PAYLOAD: begin
            if (!accept_s) begin
               state_s = PAYLOAD;
            end else if (rx_sof) begin
               frame_abort_s = 1'b1;
               flush_cnt_s   = FLUSH_N;
               state_s       = FLUSH;
            end else begin
               shift_s     = 1'b1;
               cmp_valid_s = 1'b1;
               if (!rx_eof) begin
                  state_s = PAYLOAD;
               end else if (residual_s) begin
                  state_s = TAIL;
               end else begin
                  flush_cnt_s = FLUSH_N;
                  state_s     = FLUSH;
               end
            end
         end
         TAIL: begin
            drain_s     = 1'b1;
            cmp_valid_s = 1'b1;
            flush_cnt_s = FLUSH_N;
            state_s     = FLUSH;
         end
         FLUSH: begin
            cmp_valid_s = 1'b1;
            flush_cnt_s = flush_cnt_r - FLUSH_1;
            if (flush_cnt_r <= FLUSH_1) begin
               state_s = CLEAR;
            end else begin
               state_s = FLUSH;
            end
         end
         CLEAR: begin
            cmp_clear_s = 1'b1;
            hdr_cnt_s   = {HCW{1'b0}};
            flush_cnt_s = {FCW{1'b0}};
            state_s     = IDLE;
         end
         default: begin
            hdr_cnt_s   = {HCW{1'b0}};
            flush_cnt_s = {FCW{1'b0}};
            state_s     = IDLE;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r     <= IDLE;
         hdr_cnt_r   <= {HCW{1'b0}};
         flush_cnt_r <= {FCW{1'b0}};
         rx_ready    <= 1'b1;
         cmp_valid   <= 1'b0;
         cmp_data    <= {WORD_W{1'b0}};
         cmp_clear   <= 1'b0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         state_r     <= state_s;
         hdr_cnt_r   <= hdr_cnt_s;
         flush_cnt_r <= flush_cnt_s;
         rx_ready    <= (state_s == IDLE) || (state_s == HDR) || (state_s == PAYLOAD);
         cmp_valid   <= cmp_valid_s;
         cmp_data    <= cmp_valid_s ? realign_word_s : {WORD_W{1'b0}};
         cmp_clear   <= cmp_clear_s;
         frame_done  <= cmp_clear_s;
         frame_abort <= frame_abort_s;
      end
   end

endmodule

// File: tb/tb_payload_extractor.sv
// Directed bench for payload_extractor (HDR_BYTES=14, FLUSH_WORDS=5).
module tb_payload_extractor;

   logic        clk;
   logic        n_rst;
   logic        rx_valid;
   logic        rx_sof;
   logic        rx_eof;
   logic [3:0]  rx_be;
   logic [31:0] rx_data;
   logic        rx_ready;
   logic        cmp_valid;
   logic [31:0] cmp_data;
   logic        cmp_clear;
   logic        frame_done;
   logic        frame_abort;

   int n_chk  = 0;
   int n_pass = 0;

   payload_extractor #(.HDR_BYTES(14), .FLUSH_WORDS(5)) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .rx_valid    (rx_valid),
      .rx_sof      (rx_sof),
      .rx_eof      (rx_eof),
      .rx_be       (rx_be),
      .rx_data     (rx_data),
      .rx_ready    (rx_ready),
      .cmp_valid   (cmp_valid),
      .cmp_data    (cmp_data),
      .cmp_clear   (cmp_clear),
      .frame_done  (frame_done),
      .frame_abort (frame_abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic s, input logic e,
                        input logic [3:0] be, input logic [31:0] d);
      rx_valid = v;
      rx_sof   = s;
      rx_eof   = e;
      rx_be    = be;
      rx_data  = d;
      step();
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
   endtask

   // Idle cycle with noisy qualifiers that must be ignored.
   task automatic gap();
      drive(1'b0, 1'b1, 1'b1, 4'hF, 32'hFFFF_FFFF);
   endtask

   task automatic expect_out(input string tag, input logic rdy, input logic vld,
                             input logic clr, input logic abt, input logic [31:0] d);
      logic [4:0] obs_f, exp_f;
      obs_f = {rx_ready, cmp_valid, cmp_clear, frame_done, frame_abort};
      exp_f = {rdy, vld, clr, clr, abt};
      n_chk++;
      assert ((obs_f === exp_f) && (cmp_data === d)) n_pass++;
      else $error("FAIL %s: observed rdy/vld/clr/done/abt=%b data=%h, expected %b data=%h",
                  tag, obs_f, cmp_data, exp_f, d);
   endtask

   task automatic send_header(input string tag);
      drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h0001_0203);
      expect_out({tag, " hdr0"}, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 4'hF, 32'h0405_0607);
      expect_out({tag, " hdr1"}, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 4'hF, 32'h0809_0A0B);
      expect_out({tag, " hdr2"}, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 4'hF, 32'h0C0D_0E0F);
      expect_out({tag, " hdr3"}, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic flush_clear(input string tag);
      for (int i = 0; i < 5; i++) begin
         idle();
         expect_out($sformatf("%s flush%0d", tag, i), 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      end
      idle();
      expect_out({tag, " clear"}, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      idle();
      expect_out({tag, " post"}, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic frame_full(input string tag);
      send_header(tag);
      drive(1'b1, 1'b0, 1'b0, 4'hF, 32'h1011_1213);
      expect_out({tag, " pl0"}, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0E0F_1011);
      drive(1'b1, 1'b0, 1'b1, 4'hF, 32'h1415_1617);
      expect_out({tag, " pl1"}, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1213_1415);
      idle();
      expect_out({tag, " tail"}, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1617_0000);
      flush_clear(tag);
   endtask

   initial begin
      n_rst    = 1'b0;
      rx_valid = 1'b0;
      rx_sof   = 1'b0;
      rx_eof   = 1'b0;
      rx_be    = 4'h0;
      rx_data  = 32'h0;
      step();
      step();
      expect_out("reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      n_rst = 1'b1;

      // Gap-free frame with a two-byte tail.
      frame_full("t1");

      // Single valid byte in the eof word: no tail, masked lanes are zero.
      send_header("t2");
      drive(1'b1, 1'b0, 1'b0, 4'hF, 32'h1011_1213);
      expect_out("t2 pl0", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0E0F_1011);
      drive(1'b1, 1'b0, 1'b1, 4'b1000, 32'h1415_1617);
      expect_out("t2 pl1", 1'b0, 1'b1, 1'b0, 1'b0, 32'h1213_1400);
      flush_clear("t2");

      // Runt: sof and eof in one word.
      drive(1'b1, 1'b1, 1'b1, 4'hF, 32'hAABB_CCDD);
      expect_out("t3 runt", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      idle();
      expect_out("t3 clear", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      idle();
      expect_out("t3 post", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

      // New sof mid-payload aborts; a non-sof word afterwards is dropped.
      send_header("t4");
      drive(1'b1, 1'b0, 1'b0, 4'hF, 32'h1011_1213);
      expect_out("t4 pl0", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0E0F_1011);
      drive(1'b1, 1'b1, 1'b0, 4'hF, 32'hDEAD_BEEF);
      expect_out("t4 abort", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      flush_clear("t4");
      drive(1'b1, 1'b0, 1'b0, 4'hF, 32'h1122_3344);
      expect_out("t4 drop", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      frame_full("t4b");

      // Valid toggling through header and payload.
      drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h0001_0203);
      expect_out("t5 hdr0", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      gap();
      expect_out("t5 gap0", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 4'hF, 32'h0405_0607);
      gap();
      drive(1'b1, 1'b0, 1'b0, 4'hF, 32'h0809_0A0B);
      gap();
      drive(1'b1, 1'b0, 1'b0, 4'hF, 32'h0C0D_0E0F);
      expect_out("t5 hdr3", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      gap();
      expect_out("t5 gap3", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 4'hF, 32'h1011_1213);
      expect_out("t5 pl0", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0E0F_1011);
      gap();
      expect_out("t5 gap4", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 1'b1, 4'hF, 32'h1415_1617);
      expect_out("t5 pl1", 1'b0, 1'b1, 1'b0, 1'b0, 32'h1213_1415);
      idle();
      expect_out("t5 tail", 1'b0, 1'b1, 1'b0, 1'b0, 32'h1617_0000);
      flush_clear("t5");

      // Asynchronous reset during FLUSH.
      send_header("t6");
      drive(1'b1, 1'b0, 1'b0, 4'hF, 32'h1011_1213);
      drive(1'b1, 1'b0, 1'b1, 4'hF, 32'h1415_1617);
      idle();
      idle();
      expect_out("t6 flush0", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      n_rst = 1'b0;
      #1;
      expect_out("t6 rst async", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      idle();
      expect_out("t6 rst held", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      n_rst = 1'b1;
      for (int i = 0; i < 7; i++) begin
         idle();
         expect_out($sformatf("t6 no clear %0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      end
      frame_full("t6b");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
